// File: rtl/stim_loader_pkg.sv
// Shared types for the stimulus preload sequencer: entry layout, FSM states and error codes.
package stim_loader_pkg;

    localparam int unsigned STIM_ADDR_W  = 32;
    localparam int unsigned STIM_DATA_W  = 64;
    localparam int unsigned LOADER_ERR_W = 2;

    typedef struct packed {
        logic [STIM_ADDR_W-1:0] addr;
        logic [STIM_DATA_W-1:0] data;
    } stim_entry_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StBoot,
        StDone,
        StError
    } loader_state_e;

    typedef enum logic [LOADER_ERR_W-1:0] {
        ErrNone       = 2'd0,
        ErrMisaligned = 2'd1,
        ErrBus        = 2'd2,
        ErrTimeout    = 2'd3
    } loader_err_e;

endpackage

// File: rtl/stim_loader_ctrl.sv
// Preload sequencer: streams {addr, data} entries into L2 over a req/gnt port, waits for all
// write responses, then publishes the boot address and raises fetch enable.
module stim_loader_ctrl
    import stim_loader_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic [AddrWidth-1:0]   entrypoint_i,
    input  logic                   stim_valid_i,
    output logic                   stim_ready_o,
    input  logic [AddrWidth-1:0]   stim_addr_i,
    input  logic [DataWidth-1:0]   stim_data_i,
    input  logic                   stim_last_i,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic [AddrWidth-1:0]   mem_addr_o,
    output logic                   mem_we_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    input  logic                   mem_rvalid_i,
    input  logic                   mem_err_i,
    output logic [AddrWidth-1:0]   boot_addr_o,
    output logic                   fetch_en_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [1:0]             err_code_o,
    output logic [31:0]            words_o
);

    localparam int unsigned OffW  = $clog2(DataWidth / 8);
    localparam int unsigned OutsW = $clog2(MaxOutstanding + 1);
    localparam int unsigned TmoW  = $clog2(TimeoutCycles + 1);

    loader_state_e        state_q;
    loader_err_e          err_q;
    logic [OutsW-1:0]     outs_q;
    logic [OutsW-1:0]     outs_next;
    logic [TmoW-1:0]      tmo_q;
    logic [AddrWidth-1:0] entry_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] data_q;
    logic [AddrWidth-1:0] boot_q;
    logic [31:0]          words_q;
    logic                 req_q;
    logic                 fetch_q;
    logic                 done_q;
    logic                 error_q;

    logic grant;
    logic resp;
    logic active;
    logic bus_err;
    logic tmo_hit;
    logic load_space;
    logic stim_hs;
    logic misaligned;

    assign grant   = req_q && mem_gnt_i;
    // A response with nothing outstanding (e.g. straggler after reset) is dropped.
    assign resp    = mem_rvalid_i && (outs_q != '0);
    assign active  = (state_q == StLoad) || (state_q == StDrain) || (state_q == StBoot);
    assign bus_err = active && mem_rvalid_i && mem_err_i;
    assign tmo_hit = req_q && !mem_gnt_i && (tmo_q == TmoW'(TimeoutCycles - 1));

    always_comb begin
        outs_next = outs_q;
        if (grant && !resp) begin
            outs_next = outs_q + OutsW'(1);
        end else if (!grant && resp) begin
            outs_next = outs_q - OutsW'(1);
        end
    end

    assign load_space = ({1'b0, outs_q} + {{OutsW{1'b0}}, grant}) < (OutsW + 1)'(MaxOutstanding);
    assign stim_ready_o = (state_q == StLoad) && (!req_q || mem_gnt_i) && load_space && !bus_err;
    assign stim_hs      = stim_valid_i && stim_ready_o;
    assign misaligned   = stim_addr_i[OffW-1:0] != '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            err_q   <= ErrNone;
            outs_q  <= '0;
            tmo_q   <= '0;
            entry_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            boot_q  <= '0;
            words_q <= '0;
            req_q   <= 1'b0;
            fetch_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            outs_q <= outs_next;
            if (grant) begin
                words_q <= words_q + 32'd1;
                req_q   <= 1'b0;
            end
            tmo_q <= (req_q && !mem_gnt_i) ? tmo_q + TmoW'(1) : '0;

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        entry_q <= entrypoint_i;
                        words_q <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad, StDrain, StBoot: begin
                    if (bus_err) begin
                        state_q <= StError;
                        err_q   <= ErrBus;
                        error_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= StError;
                        err_q   <= ErrTimeout;
                        error_q <= 1'b1;
                        req_q   <= 1'b0;
                    end else if (stim_hs) begin
                        if (misaligned) begin
                            state_q <= StError;
                            err_q   <= ErrMisaligned;
                            error_q <= 1'b1;
                        end else begin
                            addr_q <= stim_addr_i;
                            data_q <= stim_data_i;
                            req_q  <= 1'b1;
                            if (stim_last_i) begin
                                state_q <= StDrain;
                            end
                        end
                    end else if (state_q == StDrain) begin
                        if (!req_q && outs_next == '0) begin
                            boot_q  <= entry_q;
                            state_q <= StBoot;
                        end
                    end else if (state_q == StBoot) begin
                        fetch_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StError: begin
                    // A request stuck behind a bus error must not hold the port forever.
                    if (tmo_hit) begin
                        req_q <= 1'b0;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_q <= StError;
                end
            endcase
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = data_q;
    assign mem_we_o    = 1'b1;
    assign mem_be_o    = '1;
    assign boot_addr_o = boot_q;
    assign fetch_en_o  = fetch_q;
    assign busy_o      = active;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_code_o  = err_q;
    assign words_o     = words_q;

endmodule

// File: tb/tb_stim_loader_ctrl.sv
// Self-checking bench for stim_loader_ctrl: scoreboarded writes, a latency-programmable
// memory responder and one task per scenario.
module tb_stim_loader_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;
    localparam int unsigned TO = 16;

    logic          clk, rst_ni, start_i;
    logic [AW-1:0] entrypoint_i;
    logic          stim_valid_i, stim_ready_o, stim_last_i;
    logic [AW-1:0] stim_addr_i;
    logic [DW-1:0] stim_data_i;
    logic          mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW/8-1:0] mem_be_o;
    logic [DW-1:0] mem_wdata_o;
    logic [AW-1:0] boot_addr_o;
    logic          fetch_en_o, busy_o, done_o, error_o;
    logic [1:0]    err_code_o;
    logic [31:0]   words_o;

    stim_loader_ctrl #(
        .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .entrypoint_i(entrypoint_i),
        .stim_valid_i(stim_valid_i), .stim_ready_o(stim_ready_o), .stim_addr_i(stim_addr_i),
        .stim_data_i(stim_data_i), .stim_last_i(stim_last_i), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_err_i(mem_err_i), .boot_addr_o(boot_addr_o), .fetch_en_o(fetch_en_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_code_o(err_code_o),
        .words_o(words_o)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
    typedef struct { int due; bit err; } resp_t;

    exp_t  exp_q[$];
    resp_t resp_q[$];
    int    grant_cyc[$];
    int checks = 0, errors = 0;
    int cyc = 0, grants = 0, resps = 0, stalls = 0, outs_model = 0, peak = 0;
    int resp_lat = 1, err_grant = -1, stall_at = -1, stall_len = 0, stall_cnt = 0;
    int last_rv_cyc = -1, fe_cyc = -1;
    bit gnt_en = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: grant policy and delayed write responses.
    initial begin
        resp_t r;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (mem_req_o && grants == stall_at && stall_cnt < stall_len) begin
                mem_gnt_i = 1'b0;
                stall_cnt++;
            end else begin
                mem_gnt_i = gnt_en;
            end
            mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                r = resp_q.pop_front();
                mem_rvalid_i = 1'b1;
                mem_err_i = r.err;
            end
        end
    end

    // Monitor: scoreboard compare on grant, stall stability, outstanding limit.
    initial begin
        exp_t  e;
        resp_t r;
        logic  prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (mem_req_o && !mem_gnt_i) begin
                    stalls++;
                    checks++;
                    if (stim_ready_o !== 1'b0) begin
                        errors++;
                        $display("FAIL ready_in_stall: got %b want 0", stim_ready_o);
                    end
                    if (prev_stall) begin
                        checks++;
                        if (mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
                            errors++;
                            $display("FAIL req_stable: got %h/%h want %h/%h", mem_addr_o,
                                     mem_wdata_o, prev_addr, prev_data);
                        end
                    end
                end
                prev_stall = mem_req_o && !mem_gnt_i;
                prev_addr  = mem_addr_o;
                prev_data  = mem_wdata_o;
                checks++;
                if (stim_ready_o && (outs_model + int'(mem_req_o && mem_gnt_i)) >= MO) begin
                    errors++;
                    $display("FAIL ready_limit: ready=1 with %0d outstanding", outs_model);
                end
                if (mem_req_o && mem_gnt_i) begin
                    grants++;
                    grant_cyc.push_back(cyc);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_write: got addr %h, want no write", mem_addr_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (mem_addr_o !== e.addr || mem_wdata_o !== e.data) begin
                            errors++;
                            $display("FAIL write_data: got %h/%h want %h/%h", mem_addr_o,
                                     mem_wdata_o, e.addr, e.data);
                        end
                    end
                    r.due = cyc + resp_lat;
                    r.err = (grants == err_grant);
                    resp_q.push_back(r);
                    outs_model++;
                end
                if (mem_rvalid_i) begin
                    resps++;
                    last_rv_cyc = cyc;
                    if (outs_model > 0) outs_model--;
                end
                if (outs_model > peak) peak = outs_model;
                if (fetch_en_o && fe_cyc < 0) fe_cyc = cyc;
            end
        end
    end

    task automatic do_reset();
        rst_ni = 1'b0; start_i = 1'b0; entrypoint_i = '0;
        stim_valid_i = 1'b0; stim_addr_i = '0; stim_data_i = '0; stim_last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete(); grant_cyc.delete();
        outs_model = 0; fe_cyc = -1; stall_at = -1; stall_cnt = 0; stall_len = 0;
        err_grant = -1; gnt_en = 1; resp_lat = 1; peak = 0;
        rst_ni = 1'b1;
    endtask

    task automatic start_load(input logic [AW-1:0] ep);
        start_i = 1'b1;
        entrypoint_i = ep;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
        int n = 0;
        stim_valid_i = 1'b1; stim_addr_i = a; stim_data_i = d; stim_last_i = last;
        @(negedge clk);
        while (!stim_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!stim_ready_o) begin
            errors++;
            $display("FAIL send_timeout: entry %h not accepted in %0d cycles", a, n);
        end else if (a[2:0] == 3'b000) begin
            exp_q.push_back({a, d});
        end
        @(posedge clk); #1;
        stim_valid_i = 1'b0; stim_last_i = 1'b0;
    endtask

    task automatic wait_end(input int limit, input string name);
        int n = 0;
        while (!(done_o || error_o) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(done_o || error_o)) begin
            errors++;
            $display("FAIL %s_end: no done/error after %0d cycles", name, limit);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mem_req_o, stim_ready_o, fetch_en_o, busy_o, done_o, error_o, err_code_o} !== 8'h00
            || words_o !== 32'd0 || boot_addr_o !== '0 || mem_addr_o !== '0
            || mem_wdata_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b rdy=%b fe=%b busy=%b done=%b err=%b code=%0d",
                     mem_req_o, stim_ready_o, fetch_en_o, busy_o, done_o, error_o, err_code_o);
        end
        checks++;
        if (mem_we_o !== 1'b1 || mem_be_o !== 8'hFF) begin
            errors++;
            $display("FAIL reset_static: we=%b be=%h want 1/ff", mem_we_o, mem_be_o);
        end
    endtask

    task automatic test_basic();
        int g0;
        do_reset();
        g0 = grants;
        start_load(32'h1C00_0080);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy_o);
        end
        send(32'h1C00_0000, 64'h1111_2222_3333_4444, 1'b0);
        send(32'h1C00_0008, 64'h5555_6666_7777_8888, 1'b0);
        send(32'h1C00_0010, 64'h9999_AAAA_BBBB_CCCC, 1'b1);
        wait_end(100, "basic");
        checks++;
        if (grants - g0 != 3 || grant_cyc.size() != 3) begin
            errors++;
            $display("FAIL basic_grants: got %0d want 3", grants - g0);
        end else if (grant_cyc[2] - grant_cyc[0] != 2) begin
            errors++;
            $display("FAIL basic_b2b: grant span %0d want 2", grant_cyc[2] - grant_cyc[0]);
        end
        checks++;
        if (words_o !== 32'd3 || boot_addr_o !== 32'h1C00_0080 || fetch_en_o !== 1'b1
            || done_o !== 1'b1 || error_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: words=%0d boot=%h fe=%b done=%b err=%b busy=%b",
                     words_o, boot_addr_o, fetch_en_o, done_o, error_o, busy_o);
        end
        checks++;
        if (fe_cyc != last_rv_cyc + 2) begin
            errors++;
            $display("FAIL basic_fetch_time: got cycle %0d want %0d", fe_cyc, last_rv_cyc + 2);
        end
    endtask

    task automatic test_gnt_stall();
        int g0, s0;
        do_reset();
        g0 = grants; s0 = stalls;
        stall_at = grants + 1;
        stall_len = 5;
        start_load(32'h1C00_0100);
        for (int i = 0; i < 3; i++) begin
            send(32'h1C00_0000 + 32'(8 * i), {$urandom, $urandom}, i == 2);
        end
        wait_end(100, "stall");
        checks++;
        if (stalls - s0 != 5) begin
            errors++;
            $display("FAIL stall_cycles: got %0d want 5", stalls - s0);
        end
        checks++;
        if (grants - g0 != 3 || words_o !== 32'd3 || exp_q.size() != 0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_count: grants=%0d words=%0d left=%0d want 3/3/0",
                     grants - g0, words_o, exp_q.size());
        end
    endtask

    task automatic test_outstanding();
        int r0;
        do_reset();
        resp_lat = 20;
        r0 = resps;
        start_load(32'h1C00_0200);
        for (int i = 0; i < 8; i++) begin
            send(32'h1C00_0000 + 32'(8 * i), {$urandom, $urandom}, i == 7);
        end
        wait_end(300, "outs");
        checks++;
        if (peak != 4) begin
            errors++;
            $display("FAIL outs_peak: got %0d want 4", peak);
        end
        checks++;
        if (resps - r0 != 8 || words_o !== 32'd8 || fetch_en_o !== 1'b1) begin
            errors++;
            $display("FAIL outs_done: resps=%0d words=%0d fe=%b want 8/8/1",
                     resps - r0, words_o, fetch_en_o);
        end
        checks++;
        if (fe_cyc != last_rv_cyc + 2) begin
            errors++;
            $display("FAIL outs_fetch_time: got %0d want %0d", fe_cyc, last_rv_cyc + 2);
        end
    endtask

    task automatic test_misaligned();
        int g0;
        do_reset();
        g0 = grants;
        start_load(32'h1C00_0080);
        send(32'h1C00_0004, 64'hDEAD_BEEF_0000_0001, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (grants != g0 || mem_req_o !== 1'b0 || error_o !== 1'b1 || err_code_o !== 2'd1
            || fetch_en_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: grants=%0d req=%b err=%b code=%0d fe=%b want 0/0/1/1/0",
                     grants - g0, mem_req_o, error_o, err_code_o, fetch_en_o);
        end
    endtask

    task automatic test_timeout();
        int s0;
        do_reset();
        gnt_en = 0;
        s0 = stalls;
        start_load(32'h1C00_0080);
        send(32'h1C00_0000, 64'h0123_4567_89AB_CDEF, 1'b0);
        wait_end(100, "timeout");
        checks++;
        if (stalls - s0 != 16) begin
            errors++;
            $display("FAIL timeout_cycles: req cycles %0d want 16", stalls - s0);
        end
        checks++;
        if (mem_req_o !== 1'b0 || err_code_o !== 2'd3 || error_o !== 1'b1
            || fetch_en_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: req=%b code=%0d err=%b fe=%b want 0/3/1/0",
                     mem_req_o, err_code_o, error_o, fetch_en_o);
        end
        exp_q.delete();
        gnt_en = 1;
    endtask

    task automatic test_bus_err();
        do_reset();
        err_grant = grants + 1;
        start_load(32'h1C00_0080);
        send(32'h1C00_0000, 64'hCAFE_0000_0000_0001, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (error_o !== 1'b1 || err_code_o !== 2'd2 || fetch_en_o !== 1'b0 || busy_o !== 1'b0)
        begin
            errors++;
            $display("FAIL bus_err: err=%b code=%0d fe=%b busy=%b want 1/2/0/0",
                     error_o, err_code_o, fetch_en_o, busy_o);
        end
        stim_valid_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stim_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL err_ready: got %b want 0", stim_ready_o);
        end
        @(posedge clk); #1;
        stim_valid_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (err_code_o !== 2'd2 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky: code=%0d busy=%b want 2/0", err_code_o, busy_o);
        end
    endtask

    task automatic test_reset_drain();
        int g0, n;
        do_reset();
        resp_lat = 10;
        g0 = grants;
        start_load(32'h1C00_0080);
        send(32'h1C00_0000, 64'hAAAA_0000_0000_0001, 1'b0);
        send(32'h1C00_0008, 64'hAAAA_0000_0000_0002, 1'b1);
        n = 0;
        while (grants - g0 < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #3;
        rst_ni = 1'b0;
        outs_model = 0;
        #1;
        checks++;
        if ({mem_req_o, stim_ready_o, fetch_en_o, busy_o, done_o, error_o, err_code_o} !== 8'h00
            || words_o !== 32'd0 || boot_addr_o !== '0 || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL rst_mid: req=%b busy=%b words=%0d addr=%h want all 0",
                     mem_req_o, busy_o, words_o, mem_addr_o);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        n = 0;
        while (resp_q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || error_o !== 1'b0 || done_o !== 1'b0 || words_o !== 32'd0) begin
            errors++;
            $display("FAIL late_rvalid: busy=%b err=%b done=%b words=%0d want 0",
                     busy_o, error_o, done_o, words_o);
        end
        resp_lat = 1;
        exp_q.delete();
        start_load(32'h1C00_1000);
        send(32'h1C00_0040, 64'hBBBB_0000_0000_0001, 1'b0);
        send(32'h1C00_0048, 64'hBBBB_0000_0000_0002, 1'b1);
        wait_end(100, "fresh");
        checks++;
        if (done_o !== 1'b1 || error_o !== 1'b0 || words_o !== 32'd2
            || boot_addr_o !== 32'h1C00_1000 || fetch_en_o !== 1'b1) begin
            errors++;
            $display("FAIL fresh_load: done=%b err=%b words=%0d boot=%h want 1/0/2/1c001000",
                     done_o, error_o, words_o, boot_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gnt_stall();
        test_outstanding();
        test_misaligned();
        test_timeout();
        test_bus_err();
        test_reset_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks", checks);
        $fatal(1);
    end

endmodule
